echo_measure: RTL and testbench

ECHO_MEASURE -- requirements
Module: echo_measure

---
 rtl/echo_measure_pkg.sv | 22 ++
 rtl/echo_sync.sv | 63 ++++++
 rtl/echo_measure.sv | 169 ++++++++++++++++
 tb/tb_echo_measure.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/echo_measure_pkg.sv
// Shared types and default constants for the ultrasonic echo range meter.
package echo_measure_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2,
    ST_REPORT    = 2'd3
  } state_t;

  localparam int DEF_CLK_DIV    = 50;
  localparam int DEF_US_PER_CM  = 58;
  localparam int DEF_MAX_CM     = 400;
  localparam int DEF_TIMEOUT_US = 30000;
  localparam int DIST_W         = 9;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the asynchronous echo line, with an optional
// 3-sample glitch filter enabled by ECHO_GLITCH_FILTER_EN.
module echo_sync
  import echo_measure_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic echo_in,
  output logic echo_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = echo_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;
  logic filt_q, filt_d;
  logic stable;

  // The filtered level follows the synchronized one only once the current
  // sample and the two before it agree, so single-cycle glitches vanish.
  always_comb begin
    hist1_d = sync_q;
    hist2_d = hist1_q;
    stable  = (sync_q == hist1_q) && (hist1_q == hist2_q);
    filt_d  = stable ? sync_q : filt_q;
    echo_s  = filt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      filt_q  <= filt_d;
    end
  end
`else
  always_comb begin
    echo_s = sync_q;
  end
`endif

endmodule

// File: rtl/echo_measure.sv
// Echo pulse-width range meter: times the echo in microseconds and converts
// to centimetres with saturation and timeout. Optional ECHO_GLITCH_FILTER_EN.
module echo_measure
  import echo_measure_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int US_PER_CM  = DEF_US_PER_CM,
  parameter int MAX_CM     = DEF_MAX_CM,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              trig_start,
  input  logic              echo,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              over_range,
  output logic              timeout,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int PRESC_W = cnt_width(CLK_DIV - 1);
  localparam int US_W    = cnt_width(TIMEOUT_US);
  localparam int SUB_W   = cnt_width(US_PER_CM - 1);

  logic echo_s;

  echo_sync u_echo_sync (
    .clk     (clk_50m),
    .rst     (rst),
    .echo_in (echo),
    .echo_s  (echo_s)
  );

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [US_W-1:0]     us_q, us_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [DIST_W-1:0]   cm_q, cm_d;
  logic                over_q, over_d;
  logic [DIST_W-1:0]   dist_q, dist_d;
  logic                over_range_q, over_range_d;
  logic                timeout_q, timeout_d;

  logic                tick;
  logic                us_hit;
  logic                sub_wrap;
  logic [PRESC_W-1:0]  presc_nxt;
  logic [US_W-1:0]     us_nxt;
  logic [SUB_W-1:0]    sub_nxt;
  logic [DIST_W-1:0]   cm_nxt;
  logic                over_nxt;

  always_comb begin
    tick      = (presc_q == PRESC_W'(CLK_DIV - 1));
    presc_nxt = tick ? '0 : presc_q + 1'b1;
    us_nxt    = tick ? us_q + 1'b1 : us_q;
    us_hit    = tick && (us_q == US_W'(TIMEOUT_US - 1));
    sub_wrap  = tick && (sub_q == SUB_W'(US_PER_CM - 1));
    if (sub_wrap) begin
      sub_nxt = '0;
    end else if (tick) begin
      sub_nxt = sub_q + 1'b1;
    end else begin
      sub_nxt = sub_q;
    end
    cm_nxt   = (sub_wrap && (cm_q != DIST_W'(MAX_CM))) ? cm_q + 1'b1 : cm_q;
    over_nxt = over_q || (cm_nxt == DIST_W'(MAX_CM));
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    us_d         = us_q;
    sub_d        = sub_q;
    cm_d         = cm_q;
    over_d       = over_q;
    dist_d       = dist_q;
    over_range_d = over_range_q;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_start) begin
          state_d = ST_WAIT_RISE;
          presc_d = '0;
          us_d    = '0;
          sub_d   = '0;
          cm_d    = '0;
          over_d  = 1'b0;
        end
      end

      ST_WAIT_RISE: begin
        presc_d = presc_nxt;
        us_d    = us_nxt;
        if (echo_s) begin
          state_d = ST_MEASURE;
          presc_d = '0;
          us_d    = '0;
        end else if (us_hit) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end

      // The cycle that sees echo_s low is still counted: it balances the
      // cycle spent in WAIT_RISE detecting the rise.
      ST_MEASURE: begin
        presc_d = presc_nxt;
        us_d    = us_nxt;
        sub_d   = sub_nxt;
        cm_d    = cm_nxt;
        over_d  = over_nxt;
        if (!echo_s) begin
          state_d      = ST_REPORT;
          dist_d       = cm_nxt;
          over_range_d = over_nxt;
        end else if (us_hit) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      us_q         <= '0;
      sub_q        <= '0;
      cm_q         <= '0;
      over_q       <= 1'b0;
      dist_q       <= '0;
      over_range_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      us_q         <= us_d;
      sub_q        <= sub_d;
      cm_q         <= cm_d;
      over_q       <= over_d;
      dist_q       <= dist_d;
      over_range_q <= over_range_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    dist_cm    = dist_q;
    over_range = over_range_q;
    dist_valid = (state_q == ST_REPORT);
    timeout    = timeout_q;
    busy       = (state_q != ST_IDLE);
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_echo_measure.sv
// Directed bench for echo_measure with one-clock-per-microsecond prescaling;
// results are checked by a queue-based monitor decoupled from the drivers.
module tb_echo_measure;
  import echo_measure_pkg::*;

  localparam int TIMEOUT = 30000;
`ifdef ECHO_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic              clk_50m = 1'b0;
  logic              rst;
  logic              trig_start;
  logic              echo;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_valid;
  logic              over_range;
  logic              timeout;
  logic              busy;
  state_t            dbg_state;

  echo_measure #(
    .CLK_DIV    (1),
    .US_PER_CM  (58),
    .MAX_CM     (400),
    .TIMEOUT_US (TIMEOUT)
  ) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .trig_start (trig_start),
    .echo       (echo),
    .dist_cm    (dist_cm),
    .dist_valid (dist_valid),
    .over_range (over_range),
    .timeout    (timeout),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk_50m = ~clk_50m;

  int unsigned cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // Scoreboard state
  logic [9:0]  exp_q[$];
  int unsigned exp_cyc_q[$];
  int unsigned to_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned trig_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic [9:0]  mon_e;
  int unsigned mon_c;
  always @(negedge clk_50m) begin
    if (!rst) begin
      if (dist_valid || timeout) check("valid_timeout_exclusive", 32'(dist_valid & timeout), 0);
      if (dist_valid) begin
        check("dist_valid_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          check("dist_cm", 32'(dist_cm), 32'(mon_e[8:0]));
          check("over_range", 32'(over_range), 32'(mon_e[9]));
          check("valid_latency", cyc, mon_c);
        end
      end
      if (timeout) begin
        check("timeout_expected", 32'(to_q.size() > 0), 1);
        if (to_q.size() > 0) begin
          mon_c = to_q.pop_front();
          check("timeout_cycle", cyc, mon_c);
        end
      end
    end
  end

  // Drivers
  task automatic pulse_trig();
    trig_start = 1'b1;
    @(negedge clk_50m);
    trig_start = 1'b0;
    trig_cyc = cyc;
  endtask

  task automatic measure(input int d, input logic [9:0] exp);
    int unsigned c0;
    exp_q.push_back(exp);
    pulse_trig();
    repeat (10) @(negedge clk_50m);
    c0 = cyc;
    exp_cyc_q.push_back(c0 + d + LAT);
    echo = 1'b1;
    repeat (d / 2) @(negedge clk_50m);
    check("busy_measuring", 32'(busy), 1);
    check("state_measure", 32'(dbg_state), 32'(ST_MEASURE));
    repeat (d - d / 2) @(negedge clk_50m);
    echo = 1'b0;
    repeat (20) @(negedge clk_50m);
  endtask

  initial begin
    rst        = 1'b1;
    trig_start = 1'b0;
    echo       = 1'b0;
    repeat (3) @(negedge clk_50m);
    check("rst_dist_cm", 32'(dist_cm), 0);
    check("rst_over_range", 32'(over_range), 0);
    check("rst_dist_valid", 32'(dist_valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk_50m);

    // Nominal, truncation and repeat measurements
    measure(1160, {1'b0, 9'd20});
    measure(1217, {1'b0, 9'd20});
    measure(580, {1'b0, 9'd10});
    check("idle_after_report", 32'(busy), 0);
    // Saturation
    measure(29000, {1'b1, 9'd400});

    // Echo never rises
    pulse_trig();
    to_q.push_back(trig_cyc + TIMEOUT);
    repeat (TIMEOUT + 10) @(negedge clk_50m);
    check("timeout_busy_low", 32'(busy), 0);
    check("timeout_dist_kept", 32'(dist_cm), 400);
    check("timeout_over_kept", 32'(over_range), 1);

    // Echo already high when triggered
    exp_q.push_back({1'b0, 9'd20});
    echo = 1'b1;
    repeat (5) @(negedge clk_50m);
    pulse_trig();
    exp_cyc_q.push_back(trig_cyc + 1200 + LAT);
    repeat (1200) @(negedge clk_50m);
    echo = 1'b0;
    repeat (20) @(negedge clk_50m);

    // One-cycle low glitch at 500 us
    begin
      int unsigned c0;
`ifdef ECHO_GLITCH_FILTER_EN
      exp_q.push_back({1'b0, 9'd20});
`else
      exp_q.push_back({1'b0, 9'd8});
`endif
      pulse_trig();
      repeat (10) @(negedge clk_50m);
      c0 = cyc;
`ifdef ECHO_GLITCH_FILTER_EN
      exp_cyc_q.push_back(c0 + 1160 + LAT);
`else
      exp_cyc_q.push_back(c0 + 500 + LAT);
`endif
      echo = 1'b1;
      repeat (500) @(negedge clk_50m);
      echo = 1'b0;
      @(negedge clk_50m);
      echo = 1'b1;
      repeat (659) @(negedge clk_50m);
      echo = 1'b0;
      repeat (20) @(negedge clk_50m);
    end

    // Reset during MEASURE aborts silently
    pulse_trig();
    repeat (5) @(negedge clk_50m);
    echo = 1'b1;
    repeat (300) @(negedge clk_50m);
    rst = 1'b1;
    repeat (2) @(negedge clk_50m);
    echo = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_dist_cm", 32'(dist_cm), 0);
    check("mid_rst_over", 32'(over_range), 0);
    rst = 1'b0;
    repeat (50) @(negedge clk_50m);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Second trigger during a measurement is ignored
    begin
      int unsigned c0;
      exp_q.push_back({1'b0, 9'd10});
      pulse_trig();
      repeat (10) @(negedge clk_50m);
      c0 = cyc;
      exp_cyc_q.push_back(c0 + 580 + LAT);
      echo = 1'b1;
      repeat (300) @(negedge clk_50m);
      pulse_trig();
      repeat (279) @(negedge clk_50m);
      echo = 1'b0;
      repeat (20) @(negedge clk_50m);
    end

    for (int i = 0; i < 100 && (exp_q.size() + to_q.size()) > 0; i++) @(negedge clk_50m);
    check("results_outstanding", 32'(exp_q.size() + to_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
